// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: drives one external 1-bit slice LSB first, WIDTH+1 cycles per op.
// Optional signed-overflow flag enabled by defining ALU_SERIAL_OVF_EN.
module alu_serial_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             c_out,
    output logic             err,
    output logic             ovf,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic [2:0]       slice_ctr,
    input  logic             slice_r,
    input  logic             slice_cout
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] r_sh_q, r_sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             c_out_q, c_out_d;
    logic             err_q, err_d;
    logic             op_legal;
    logic             op_arith;
`ifdef ALU_SERIAL_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    assign op_legal = (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
                      (op == OP_SUB) || (op == OP_XOR);
    assign op_arith = (op_q == OP_ADD) || (op_q == OP_SUB);

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        r_sh_d   = r_sh_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        op_d     = op_q;
        result_d = result_q;
        zero_d   = zero_q;
        c_out_d  = c_out_q;
        err_d    = err_q;
`ifdef ALU_SERIAL_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    op_d    = op;
                    r_sh_d  = '0;
                    cnt_d   = '0;
                    carry_d = (op == OP_SUB);
                    if (op_legal) begin
                        state_d = S_RUN;
                    end else begin
                        state_d  = S_DONE;
                        result_d = '0;
                        zero_d   = 1'b1;
                        c_out_d  = 1'b0;
                        err_d    = 1'b1;
`ifdef ALU_SERIAL_OVF_EN
                        ovf_d    = 1'b0;
`endif
                    end
                end
            end
            S_RUN: begin
                r_sh_d  = {slice_r, r_sh_q[WIDTH-1:1]};
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = slice_cout;
                // Results latch on the final RUN edge so they appear together with done.
                if (cnt_q == CNT_LAST) begin
                    state_d  = S_DONE;
                    result_d = r_sh_d;
                    zero_d   = (r_sh_d == '0);
                    c_out_d  = op_arith ? slice_cout : 1'b0;
                    err_d    = 1'b0;
`ifdef ALU_SERIAL_OVF_EN
                    ovf_d    = op_arith ? (carry_q ^ slice_cout) : 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            r_sh_q   <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            op_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            c_out_q  <= 1'b0;
            err_q    <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            r_sh_q   <= r_sh_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            op_q     <= op_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            c_out_q  <= c_out_d;
            err_q    <= err_d;
`ifdef ALU_SERIAL_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign c_out     = c_out_q;
    assign err       = err_q;
`ifdef ALU_SERIAL_OVF_EN
    assign ovf       = ovf_q;
`else
    assign ovf       = 1'b0;
`endif
    assign slice_a   = (state_q == S_RUN) ? a_sh_q[0] : 1'b0;
    assign slice_b   = (state_q == S_RUN) ? b_sh_q[0] : 1'b0;
    assign slice_cin = (state_q == S_RUN) ? carry_q   : 1'b0;
    assign slice_ctr = (state_q == S_RUN) ? op_q      : 3'b000;

endmodule
